multibyte_add_sequencer: RTL



---
 rtl/multibyte_add_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multibyte_add_sequencer.sv
// Widens an external 8-bit ripple-carry adder to 8*NBYTES-bit add/subtract,
// one byte per clock LSB first, with C/Z/N/V flags for the status register.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic         in_cin,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [7:0]   add_x,
  output logic [7:0]   add_y,
  output logic         add_cin,
  input  logic [7:0]   add_z,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_c,
  output logic         out_z,
  output logic         out_n,
  output logic         out_v
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NBYTES-1:0][7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   zacc_q, zacc_d;
  logic                   c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic                   last;

  assign last = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          // Subtraction is A + ~B + carry; B is inverted once at latch time.
          b_d     = in_op[1] ? ~in_b : in_b;
          carry_d = in_op[0] ? in_cin : in_op[1];
          idx_d   = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = add_z;
        carry_d      = add_cout;
        zacc_d       = zacc_q & (add_z == 8'h00);
        idx_d        = idx_q + IW'(1);
        if (last) begin
          state_d = DONE;
          c_d     = add_cout;
          z_d     = zacc_q & (add_z == 8'h00);
          n_d     = add_z[7];
          v_d     = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) & (add_z[7] != a_q[NBYTES-1][7]);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    add_x   = 8'h00;
    add_y   = 8'h00;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_x   = a_q[idx_q];
      add_y   = b_q[idx_q];
      add_cin = carry_q;
    end
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_c      = c_q;
  assign out_z      = z_q;
  assign out_n      = n_q;
  assign out_v      = v_q;

endmodule
